// File: rtl/key_debounce_bank_pkg.sv
// rtl/key_debounce_bank_pkg.sv - shared constants and lane-state encoding for the key debounce bank
package key_debounce_bank_pkg;

    localparam int N_KEYS_DEFAULT = 4;
    // 20 ms of stability at a 50 MHz system clock
    localparam int DEBOUNCE_50MHZ = 1000000;
    localparam int CNT_W_DEFAULT  = 20;

    localparam logic [N_KEYS_DEFAULT-1:0] KEY_IDLE = {N_KEYS_DEFAULT{1'b1}};

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/key_debounce_lane.sv
// rtl/key_debounce_lane.sv - one key lane: 2-flop synchronizer, stability counter, clean level and edge strobes
module key_debounce_lane
    import key_debounce_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic clean_out,
    output logic press_strb,
    output logic release_strb
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    lane_state_t      state;
    logic [CNT_W-1:0] cnt;

    // Idle level is high, so the synchronizer resets to 1 to avoid a spurious press after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= STABLE;
            cnt          <= '0;
            clean_out    <= 1'b1;
            press_strb   <= 1'b0;
            release_strb <= 1'b0;
        end else begin
            press_strb   <= 1'b0;
            release_strb <= 1'b0;
            case (state)
                STABLE: begin
                    if (s2 != clean_out) begin
                        state <= CHECK;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                CHECK: begin
                    if (s2 == clean_out) begin
                        cnt   <= '0;
                        state <= STABLE;
                    end else if (cnt == CNT_LAST) begin
                        // New level has held long enough: accept it and flag the edge direction.
                        clean_out    <= s2;
                        cnt          <= '0;
                        state        <= STABLE;
                        press_strb   <= ~s2;
                        release_strb <= s2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce_bank.sv
// rtl/key_debounce_bank.sv - bank of independent debounced key lanes with press/release strobes
module key_debounce_bank
    import key_debounce_bank_pkg::*;
#(
    parameter int N_KEYS          = N_KEYS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] clean_out,
    output logic [N_KEYS-1:0] press_strb,
    output logic [N_KEYS-1:0] release_strb
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .key_raw     (key_raw[i]),
            .clean_out   (clean_out[i]),
            .press_strb  (press_strb[i]),
            .release_strb(release_strb[i])
        );
    end

endmodule

// File: doc/key_debounce_bank.md
Name: key_debounce_bank

Overview:
- Producer side of the 4-lane key interface. Takes raw, bouncy, active-low push-button levels from the board pins.
- Outputs the clean, stable active-low key vector consumed by the key press-pulse logic (idle = 4'b1111).
- Also outputs per-lane one-cycle press/release strobes for scoring and sound logic.
- One instance sits between the top-level key pins and the game input path.

Parameters:
- N_KEYS, 4: number of key lanes.
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a new level must hold before it is accepted (20 ms at 50 MHz). Legal range 2..2^CNT_W-1; benches override it to 4.
- CNT_W, 20: width of each lane's stability counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- key_raw  input  N_KEYS  raw pin levels, active-low, asynchronous to clk.
- clean_out  output  N_KEYS  debounced levels, active-low; idle all-ones.
- press_strb  output  N_KEYS  1-cycle pulse per lane when clean_out[i] goes 1->0.
- release_strb  output  N_KEYS  1-cycle pulse per lane when clean_out[i] goes 0->1.

Behaviour:
- Reset (rst low, asynchronous):
  - sync stages = all ones; clean_out = all ones.
  - stability counters = 0; press_strb = release_strb = 0; FSMs in STABLE.
  - Deasserting rst mid-bounce discards all partial counts.
- Synchronizer: two flops per lane (s1, s2), reset to 1. Only s2 is used downstream.
- Per-lane FSM, two states, evaluated every rising edge:
  - STABLE: s2 == clean_out[i]; counter held at 0. If s2 != clean_out[i] -> go to CHECK, counter <= 1.
  - CHECK, s2 == clean_out[i] (bounce back): counter <= 0 -> STABLE. No output change.
  - CHECK, s2 != clean_out[i], counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - CHECK, s2 != clean_out[i], counter == DEBOUNCE_CYCLES-1: clean_out[i] <= s2; counter <= 0; -> STABLE; the matching strobe is registered high for exactly that one cycle.
- Latency:
  - Raw edge first sampled into s1 at edge 1 -> s2 at edge 2.
  - clean_out[i] and its strobe change at edge 2+DEBOUNCE_CYCLES.
  - The strobe is coincident with the clean_out change.
- Counter is saturating by construction: it never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Lanes are fully independent:
  - Simultaneous transitions on several lanes give simultaneous strobes in the same cycle.
  - One lane bouncing never disturbs another lane's counter.
- Glitch rejection:
  - Any pulse (high or low) shorter than DEBOUNCE_CYCLES cycles after synchronization is ignored entirely.
  - A single matching sample restarts the count.
- press_strb[i] and release_strb[i] are never high together. Both are 0 whenever clean_out is unchanged.
- All outputs are registered; no combinational path from key_raw to any output.

Decomposition:
- Shared package:
  - KEY_IDLE constant = {N_KEYS{1'b1}}.
  - Lane-state encoding: STABLE=1'b0, CHECK=1'b1.
  - Default DEBOUNCE_CYCLES for 50 MHz.
- One natural sub-module: key_debounce_lane. It holds one lane's synchronizer, counter, FSM, clean bit and strobes, parameterized by DEBOUNCE_CYCLES/CNT_W. key_debounce_bank generate-instantiates N_KEYS of them.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold rst low with key_raw=4'b0000 -> clean_out=4'b1111, strobes 0. Release rst with keys still 0000 -> clean_out=4'b0000 at edge 6 after release, with press_strb=4'b1111 for one cycle.
- Clean press: key_raw 1111->1110, first sampled at edge 1 -> clean_out=4'b1110 and press_strb=4'b0001 at edge 6 only. Release back to 1111 -> release_strb=4'b0001 4+2 edges later.
- Bounce: key_raw[2] toggles 0,1,0,1 every 2 cycles, then holds 0 -> no output change during toggling. clean_out[2]=0 exactly 6 edges after the final settle, with a single press_strb[2].
- Glitch: key_raw[3] low for 3 cycles then high -> clean_out stays 1111, no strobes.
- Simultaneous: lanes 0 and 3 press on the same cycle while lane 1 bounces -> press_strb=4'b1001 in one cycle; lane 1 unaffected.
- Reset mid-count: assert rst 2 cycles after key_raw[1] falls -> immediate clean_out=1111, strobes 0. After release, the full 6-edge latency restarts.
